// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back path: requester indices and round-robin helpers.
// Decode and wb stages both import this so requester numbering stays consistent.
package wb_arbiter_pkg;
   localparam int         NREQ    = 3;
   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_LD  = 2'd1;
   localparam logic [1:0] SRC_MUL = 2'd2;

   // Next index in the circular search order; the last requester wraps to the first.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == SRC_MUL) ? SRC_ALU : idx + 2'd1;
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] g);
      return g[2] ? SRC_MUL : (g[1] ? SRC_LD : SRC_ALU);
   endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Requester handshake plus register-file write port of the write-back arbiter.
// slave = the arbiter; master = requesters and the register-file side.
interface wb_arbiter_if
   import wb_arbiter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int REGW  = 3
);
   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_ready;
   logic [WIDTH-1:0] req_data0, req_data1, req_data2;
   logic [REGW-1:0]  req_reg0,  req_reg1,  req_reg2;
   logic             stall;
   logic             flush;
   logic             wr_en;
   logic [REGW-1:0]  wr_reg;
   logic [WIDTH-1:0] wr_data;
   logic [1:0]       wr_src;

   modport slave (
      input  req_valid, req_data0, req_data1, req_data2,
             req_reg0, req_reg1, req_reg2, stall, flush,
      output req_ready, wr_en, wr_reg, wr_data, wr_src
   );

   modport master (
      output req_valid, req_data0, req_data1, req_data2,
             req_reg0, req_reg1, req_reg2, stall, flush,
      input  req_ready, wr_en, wr_reg, wr_data, wr_src
   );
endinterface

// File: rtl/wb_arbiter_rr_arb3.sv
// Three-way round-robin grant: search starts at ptr_i and the first valid requester wins.
// Purely combinational; enable_i low forces an all-zero grant.
module rr_arb3
   import wb_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] valid_i,
   input  logic [1:0]      ptr_i,
   input  logic            enable_i,
   output logic [NREQ-1:0] grant_o
);
   always_comb begin
      logic [1:0] idx;
      logic       found;
      grant_o = '0;
      found   = 1'b0;
      idx     = ptr_i;
      for (int k = 0; k < NREQ; k++) begin
         if (enable_i && !found && valid_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
         idx = rr_next(idx);
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin among ALU/load/multi-cycle results into one
// register-file write port, with a single output register that stalls and flushes.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int REGW  = 3
) (
   input  logic      clk,
   input  logic      rst,
   wb_arbiter_if.slave bus
);
   logic             wr_en_q,   wr_en_d;
   logic [REGW-1:0]  wr_reg_q,  wr_reg_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;
   logic [1:0]       wr_src_q,  wr_src_d;
   logic [1:0]       ptr_q,     ptr_d;

   logic            hold;
   logic            arb_en;
   logic [NREQ-1:0] grant;
   logic [1:0]      gidx;

   // A pending write that the register file cannot take blocks new grants;
   // reset gates grants too so ready is low regardless of the clock.
   assign hold   = bus.stall && wr_en_q;
   assign arb_en = !rst && !bus.flush && !hold;

   rr_arb3 u_arb (
      .valid_i  (bus.req_valid),
      .ptr_i    (ptr_q),
      .enable_i (arb_en),
      .grant_o  (grant)
   );

   assign bus.req_ready = grant;
   assign gidx          = onehot_idx(grant);

   always_comb begin
      wr_en_d   = wr_en_q;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      wr_src_d  = wr_src_q;
      ptr_d     = ptr_q;
      if (bus.flush) begin
         wr_en_d = 1'b0;
      end else if (hold) begin
         wr_en_d = 1'b1;
      end else if (|grant) begin
         wr_en_d  = 1'b1;
         wr_src_d = gidx;
         ptr_d    = rr_next(gidx);
         unique case (gidx)
            SRC_LD:  begin wr_reg_d = bus.req_reg1; wr_data_d = bus.req_data1; end
            SRC_MUL: begin wr_reg_d = bus.req_reg2; wr_data_d = bus.req_data2; end
            default: begin wr_reg_d = bus.req_reg0; wr_data_d = bus.req_data0; end
         endcase
      end else begin
         wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         wr_src_q  <= SRC_ALU;
         ptr_q     <= SRC_ALU;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
         wr_src_q  <= wr_src_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_reg  = wr_reg_q;
   assign bus.wr_data = wr_data_q;
   assign bus.wr_src  = wr_src_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for round-robin streaming plus
// hand sequences for register 0, stall, flush and asynchronous reset.
module tb_wb_arbiter;
   localparam int WIDTH = 16;
   localparam int REGW  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [WIDTH-1:0] dat_a [3];
   logic [REGW-1:0]  reg_a [3];

   wb_arbiter_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();

   wb_arbiter #(.WIDTH(WIDTH), .REGW(REGW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.req_data0 = dat_a[0];
   assign bus.req_data1 = dat_a[1];
   assign bus.req_data2 = dat_a[2];
   assign bus.req_reg0  = reg_a[0];
   assign bus.req_reg1  = reg_a[1];
   assign bus.req_reg2  = reg_a[2];

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]       valid;
      logic             stall;
      logic             flush;
      logic [2:0]       ready;
      logic             en;
      logic [REGW-1:0]  rg;
      logic [WIDTH-1:0] data;
      logic [1:0]       src;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mkv(input logic [2:0] v, input logic [2:0] rdy, input logic en,
                                input logic [REGW-1:0] rg, input logic [WIDTH-1:0] d,
                                input logic [1:0] src);
      vec_t t;
      t.valid = v; t.stall = 1'b0; t.flush = 1'b0;
      t.ready = rdy; t.en = en; t.rg = rg; t.data = d; t.src = src;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [2:0] rdy, input logic en,
                      input logic [REGW-1:0] rg, input logic [WIDTH-1:0] d, input logic [1:0] src);
      checks++;
      if (bus.req_ready !== rdy || bus.wr_en !== en || bus.wr_reg !== rg ||
          bus.wr_data !== d || bus.wr_src !== src) begin
         failures++;
         $display("FAIL %s: got ready=%b en=%b reg=%0d data=%h src=%0d, want ready=%b en=%b reg=%0d data=%h src=%0d",
                  nm, bus.req_ready, bus.wr_en, bus.wr_reg, bus.wr_data, bus.wr_src,
                  rdy, en, rg, d, src);
      end
   endtask

   task automatic drv(input logic [2:0] v, input logic s, input logic f);
      bus.req_valid = v;
      bus.stall     = s;
      bus.flush     = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requesters must hold data/reg stable while waiting for ready.
   logic [2:0]       pv, pr;
   logic [WIDTH-1:0] pd [3];
   logic [REGW-1:0]  prg [3];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (pv[i] && !pr[i] && bus.req_valid[i])
               assert (dat_a[i] == pd[i] && reg_a[i] == prg[i])
               else $error("FAIL protocol: requester %0d changed data while waiting", i);
         end
      end
      pv = bus.req_valid;
      pr = bus.req_ready;
      for (int i = 0; i < 3; i++) begin
         pd[i]  = dat_a[i];
         prg[i] = reg_a[i];
      end
   end

   initial begin
      dat_a[0] = 16'hA000; dat_a[1] = 16'hB111; dat_a[2] = 16'hC222;
      reg_a[0] = 3'd1;     reg_a[1] = 3'd2;     reg_a[2] = 3'd3;

      vecs[0] = mkv(3'b111, 3'b001, 1'b0, 3'd0, 16'h0000, 2'd0);
      vecs[1] = mkv(3'b111, 3'b010, 1'b1, 3'd1, 16'hA000, 2'd0);
      vecs[2] = mkv(3'b111, 3'b100, 1'b1, 3'd2, 16'hB111, 2'd1);
      vecs[3] = mkv(3'b111, 3'b001, 1'b1, 3'd3, 16'hC222, 2'd2);
      vecs[4] = mkv(3'b111, 3'b010, 1'b1, 3'd1, 16'hA000, 2'd0);
      vecs[5] = mkv(3'b111, 3'b100, 1'b1, 3'd2, 16'hB111, 2'd1);
      vecs[6] = mkv(3'b000, 3'b000, 1'b1, 3'd3, 16'hC222, 2'd2);
      vecs[7] = mkv(3'b000, 3'b000, 1'b0, 3'd3, 16'hC222, 2'd2);

      // Reset with every requester asking.
      drv(3'b111, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", 3'b000, 1'b0, 3'd0, 16'h0000, 2'd0);
      tick();
      rst = 1'b0;

      foreach (vecs[i]) begin
         drv(vecs[i].valid, vecs[i].stall, vecs[i].flush);
         @(negedge clk);
         chk($sformatf("vec%0d", i), vecs[i].ready, vecs[i].en, vecs[i].rg, vecs[i].data, vecs[i].src);
         tick();
      end

      // Only requester 2 at ptr=0, writing register 0; ptr must wrap to 0.
      dat_a[2] = 16'h1234; reg_a[2] = 3'd0;
      drv(3'b100, 1'b0, 1'b0); @(negedge clk);
      chk("only2_grant", 3'b100, 1'b0, 3'd3, 16'hC222, 2'd2); tick();
      drv(3'b000, 1'b0, 1'b0); @(negedge clk);
      chk("reg0_write", 3'b000, 1'b1, 3'd0, 16'h1234, 2'd2); tick();
      drv(3'b011, 1'b0, 1'b0); @(negedge clk);
      chk("ptr_wrap", 3'b001, 1'b0, 3'd0, 16'h1234, 2'd2); tick();
      dat_a[2] = 16'hC222; reg_a[2] = 3'd3;
      drv(3'b000, 1'b0, 1'b0); @(negedge clk);
      chk("after_wrap", 3'b000, 1'b1, 3'd1, 16'hA000, 2'd0); tick();

      // Stall holds BEEF/r5, then releases with the next grant the same cycle.
      dat_a[1] = 16'hBEEF; reg_a[1] = 3'd5;
      drv(3'b010, 1'b0, 1'b0); @(negedge clk);
      chk("beef_grant", 3'b010, 1'b0, 3'd1, 16'hA000, 2'd0); tick();
      for (int k = 0; k < 3; k++) begin
         drv(3'b111, 1'b1, 1'b0); @(negedge clk);
         chk($sformatf("stall_hold%0d", k), 3'b000, 1'b1, 3'd5, 16'hBEEF, 2'd1); tick();
      end
      drv(3'b111, 1'b0, 1'b0); @(negedge clk);
      chk("stall_release", 3'b100, 1'b1, 3'd5, 16'hBEEF, 2'd1); tick();
      drv(3'b000, 1'b0, 1'b0); @(negedge clk);
      chk("post_stall", 3'b000, 1'b1, 3'd3, 16'hC222, 2'd2); tick();

      // Stall with an empty output register still grants.
      drv(3'b001, 1'b1, 1'b0); @(negedge clk);
      chk("stall_empty", 3'b001, 1'b0, 3'd3, 16'hC222, 2'd2); tick();
      drv(3'b001, 1'b1, 1'b0); @(negedge clk);
      chk("stall_full", 3'b000, 1'b1, 3'd1, 16'hA000, 2'd0); tick();
      drv(3'b000, 1'b0, 1'b0); @(negedge clk);
      chk("stall_commit", 3'b000, 1'b1, 3'd1, 16'hA000, 2'd0); tick();

      // Flush drops the pending write and leaves ptr at 1.
      drv(3'b001, 1'b0, 1'b0); @(negedge clk);
      chk("pre_flush", 3'b001, 1'b0, 3'd1, 16'hA000, 2'd0); tick();
      drv(3'b010, 1'b0, 1'b1); @(negedge clk);
      chk("flush_noready", 3'b000, 1'b1, 3'd1, 16'hA000, 2'd0); tick();
      drv(3'b111, 1'b0, 1'b0); @(negedge clk);
      chk("flush_after", 3'b010, 1'b0, 3'd1, 16'hA000, 2'd0); tick();
      drv(3'b000, 1'b0, 1'b0); @(negedge clk);
      chk("flush_next", 3'b000, 1'b1, 3'd5, 16'hBEEF, 2'd1); tick();

      // Flush wins over a stalled write.
      drv(3'b100, 1'b0, 1'b0); @(negedge clk);
      chk("pre_fs", 3'b100, 1'b0, 3'd5, 16'hBEEF, 2'd1); tick();
      drv(3'b111, 1'b1, 1'b1); @(negedge clk);
      chk("flush_stall", 3'b000, 1'b1, 3'd3, 16'hC222, 2'd2); tick();
      drv(3'b000, 1'b0, 1'b0); @(negedge clk);
      chk("flush_stall_drop", 3'b000, 1'b0, 3'd3, 16'hC222, 2'd2); tick();

      // Asynchronous reset in the middle of a stalled write.
      drv(3'b001, 1'b0, 1'b0); @(negedge clk);
      chk("pre_rst", 3'b001, 1'b0, 3'd3, 16'hC222, 2'd2); tick();
      drv(3'b111, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 chk("async_rst", 3'b000, 1'b0, 3'd0, 16'h0000, 2'd0);
      tick();
      rst = 1'b0;
      drv(3'b111, 1'b0, 1'b0); @(negedge clk);
      chk("rst_restart", 3'b001, 1'b0, 3'd0, 16'h0000, 2'd0); tick();
      drv(3'b111, 1'b0, 1'b0); @(negedge clk);
      chk("rst_second", 3'b010, 1'b1, 3'd1, 16'hA000, 2'd0); tick();
      drv(3'b000, 1'b0, 1'b0); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, write-back data width.
REQ-002 SHALL have parameter REGW, default 3, register-specifier width.
REQ-003 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have req_valid  input  3  per-requester write request (bit0 ALU, bit1 load, bit2 multi-cycle unit).
REQ-006 SHALL have req_data0/1/2  input  WIDTH each  result data of requester 0/1/2.
REQ-007 SHALL have req_reg0/1/2  input  REGW each  destination register of requester 0/1/2.
REQ-008 SHALL have req_ready  output  3  per-requester grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 SHALL have stall  input  1  register-file write port busy; the current output write is not consumed.
REQ-010 SHALL have flush  input  1  discard the pending output write and suppress grants this cycle.
REQ-011 SHALL have wr_en  output  1  register-file write enable.
REQ-012 SHALL have wr_reg  output  REGW  register-file write address.
REQ-013 SHALL have wr_data  output  WIDTH  register-file write data.
REQ-014 SHALL have wr_src  output  2  index of the requester that produced the current output (3 unused).

Function
REQ-015 SHALL drive req_ready combinationally; at most one bit high per cycle.
REQ-016 SHALL hold req_ready at 3'b000 whenever flush=1 or (stall=1 and wr_en=1).
REQ-017 SHALL select by round-robin: search order ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
REQ-018 SHALL update ptr to (granted index + 1) mod 3 after a transfer (2 wraps to 0); ptr holds when no transfer occurs.
REQ-019 SHALL register a transfer: next cycle wr_en=1, wr_reg/wr_data/wr_src = the granted requester's reg/data/index (latency 1 cycle).
REQ-020 SHALL treat a write as committed in any cycle with wr_en=1 and stall=0.
REQ-021 SHALL hold wr_en, wr_reg, wr_data and wr_src unchanged while stall=1 and wr_en=1 and flush=0.
REQ-022 SHALL accept a new grant while stall=1 and wr_en=0 (the output register is empty).
REQ-023 SHALL set wr_en=0 on the next edge after a cycle with no transfer and no held write; wr_reg/wr_data/wr_src then hold their last values.
REQ-024 SHALL give flush priority over stall and requests: next edge wr_en=0, ptr unchanged, no transfer.
REQ-025 SHALL pass register 0 through like any other register, with no special case.
REQ-026 SHALL sustain one transfer per cycle under continuous requests with stall=0.
REQ-027 Requesters SHALL keep data/reg stable while valid=1 and ready=0; the bench checks this as a protocol assertion.

Reset
REQ-028 SHALL, while rst=1 irrespective of clk, force wr_en=0, wr_reg=0, wr_data=0, wr_src=0, ptr=0 and req_ready=3'b000.
REQ-029 SHALL drop any held or in-flight write on reset mid-operation; after release, arbitration restarts at requester 0.

Structure
REQ-030 SHALL take requester-index encodings (SRC_ALU=0, SRC_LD=1, SRC_MUL=2) and NREQ=3 from a shared constants include used by the decode and wb stages.
REQ-031 SHALL place grant logic in one sub-module, rr_arb3 (inputs valid[2:0], ptr[1:0], enable; output one-hot grant[2:0]).
REQ-032 SHALL keep the output register and ptr in wb_arbiter itself.

Verification
REQ-033 Reset with all requests valid -> all outputs 0 during reset; first cycle after release grants requester 0, ptr becomes 1.
REQ-034 req_valid=3'b111 held 6 cycles, stall=0 -> grant order 0,1,2,0,1,2; wr_src follows one cycle later; wr_en=1 continuously.
REQ-035 Output holds data 16'hBEEF, reg 5; stall=1 for 3 cycles -> outputs unchanged, req_ready=0; stall drops -> commit, next grant issued that cycle.
REQ-036 flush=1 while wr_en=1 and req_valid=3'b010 -> wr_en=0 next cycle, no ready that cycle, ptr unchanged; requester 1 granted the cycle after flush drops.
REQ-037 Only requester 2 valid at ptr=0 -> requester 2 granted; ptr wraps to 0; wr_reg=0 with data 16'h1234 is written normally.
REQ-038 rst asserted mid-stall with wr_en=1 -> wr_en=0 immediately (asynchronous); held write never commits.
